// File: rtl/edge_delay_eq_n.sv
// Per-channel programmable edge delay with cancellation of pulses shorter than the
// pending delay, plus an undelayed reference level and a per-channel bypass.
module edge_delay_eq_n #(
  parameter int NUM_CH = 3,
  parameter int DLY_W  = 4
) (
  input  logic                    clk_x10,
  input  logic                    g_rst,
  input  logic [NUM_CH-1:0]       rising_edge,
  input  logic [NUM_CH-1:0]       falling_edge,
  input  logic [NUM_CH*DLY_W-1:0] rising_delay,
  input  logic [NUM_CH*DLY_W-1:0] falling_delay,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       bypass,
  input  logic                    swallow_clr,
  output logic [NUM_CH-1:0]       eq_delay_output,
  output logic [NUM_CH-1:0]       reference_output,
  output logic [NUM_CH-1:0]       swallow_flag,
  output logic [NUM_CH-1:0]       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RISE_DLY = 3'd1,
    HIGH     = 3'd2,
    FALL_DLY = 3'd3,
    LOW      = 3'd4
  } state_t;

  logic [NUM_CH*DLY_W-1:0] shadow_rise_r;
  logic [NUM_CH*DLY_W-1:0] shadow_fall_r;

  // shadow delay registers, written only on cfg_load
  always_ff @(posedge clk_x10) begin
    if (g_rst) begin
      shadow_rise_r <= '0;
      shadow_fall_r <= '0;
    end else if (cfg_load) begin
      shadow_rise_r <= rising_delay;
      shadow_fall_r <= falling_delay;
    end else begin
      shadow_rise_r <= shadow_rise_r;
      shadow_fall_r <= shadow_fall_r;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t           state_r;
    logic [DLY_W-1:0] cnt_r;
    logic [DLY_W-1:0] act_rise_r;
    logic [DLY_W-1:0] act_fall_r;
    logic             ref_r;
    logic             swallow_r;
    logic             rise_s;
    logic             fall_s;
    logic             in_dly_s;
    logic             cancel_s;
    logic             fsm_level_s;

    assign rise_s      = rising_edge[k];
    assign fall_s      = falling_edge[k];
    assign in_dly_s    = (state_r == RISE_DLY) || (state_r == FALL_DLY);
    assign cancel_s    = ((state_r == RISE_DLY) && fall_s) || ((state_r == FALL_DLY) && rise_s);
    assign fsm_level_s = (state_r == HIGH) || (state_r == FALL_DLY);

    // bypass muxes two registered levels, so toggling it needs no resync
    assign eq_delay_output[k]  = bypass[k] ? ref_r : fsm_level_s;
    assign reference_output[k] = ref_r;
    assign swallow_flag[k]     = swallow_r;
    assign busy[k]             = in_dly_s;

    // channel FSM, delay counter, active delays, reference level and swallow flag
    always_ff @(posedge clk_x10) begin
      if (g_rst) begin
        state_r    <= IDLE;
        cnt_r      <= '0;
        act_rise_r <= '0;
        act_fall_r <= '0;
        ref_r      <= 1'b0;
        swallow_r  <= 1'b0;
      end else begin
        if (rise_s) begin
          ref_r <= 1'b1;
        end else if (fall_s) begin
          ref_r <= 1'b0;
        end else begin
          ref_r <= ref_r;
        end

        if (cancel_s) begin
          swallow_r <= 1'b1;
        end else if (swallow_clr) begin
          swallow_r <= 1'b0;
        end else begin
          swallow_r <= swallow_r;
        end

        // active delays track the shadow copy except while a delay is running
        if (!in_dly_s) begin
          act_rise_r <= shadow_rise_r[k*DLY_W +: DLY_W];
          act_fall_r <= shadow_fall_r[k*DLY_W +: DLY_W];
        end else begin
          act_rise_r <= act_rise_r;
          act_fall_r <= act_fall_r;
        end

        case (state_r)
          IDLE, LOW, HIGH: begin
            cnt_r <= '0;
            if (rise_s) begin
              if (state_r != HIGH) begin
                state_r <= (act_rise_r == '0) ? HIGH : RISE_DLY;
              end else begin
                state_r <= state_r;
              end
            end else if (fall_s && (state_r != LOW)) begin
              state_r <= (act_fall_r == '0) ? LOW : FALL_DLY;
            end else begin
              state_r <= state_r;
            end
          end
          RISE_DLY: begin
            if (fall_s) begin
              state_r <= LOW;
              cnt_r   <= '0;
            end else if (cnt_r == act_rise_r - DLY_W'(1)) begin
              state_r <= HIGH;
              cnt_r   <= '0;
            end else begin
              state_r <= state_r;
              cnt_r   <= cnt_r + DLY_W'(1);
            end
          end
          FALL_DLY: begin
            if (rise_s) begin
              state_r <= HIGH;
              cnt_r   <= '0;
            end else if (cnt_r == act_fall_r - DLY_W'(1)) begin
              state_r <= LOW;
              cnt_r   <= '0;
            end else begin
              state_r <= state_r;
              cnt_r   <= cnt_r + DLY_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_edge_delay_eq_n.sv
// Scoreboard bench for edge_delay_eq_n: stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_edge_delay_eq_n;
  localparam int NCH = 8;
  localparam int DW  = 5;

  logic              clk_x10;
  logic              g_rst;
  logic [NCH-1:0]    rising_edge;
  logic [NCH-1:0]    falling_edge;
  logic [NCH*DW-1:0] rising_delay;
  logic [NCH*DW-1:0] falling_delay;
  logic              cfg_load;
  logic [NCH-1:0]    bypass;
  logic              swallow_clr;
  logic [NCH-1:0]    eq_delay_output;
  logic [NCH-1:0]    reference_output;
  logic [NCH-1:0]    swallow_flag;
  logic [NCH-1:0]    busy;

  edge_delay_eq_n #(.NUM_CH(NCH), .DLY_W(DW)) dut (
    .clk_x10(clk_x10), .g_rst(g_rst), .rising_edge(rising_edge), .falling_edge(falling_edge),
    .rising_delay(rising_delay), .falling_delay(falling_delay), .cfg_load(cfg_load),
    .bypass(bypass), .swallow_clr(swallow_clr), .eq_delay_output(eq_delay_output),
    .reference_output(reference_output), .swallow_flag(swallow_flag), .busy(busy)
  );

  typedef struct {
    int   cyc;
    int   sel;  // 0 eq, 1 ref, 2 swallow, 3 busy
    int   ch;
    logic val;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk_x10 = 1'b0;
    forever #5 clk_x10 = ~clk_x10;
  end

  always @(posedge clk_x10) cyc <= cyc + 1;

  function automatic logic get_out(int sel, int ch);
    case (sel)
      0: return eq_delay_output[ch];
      1: return reference_output[ch];
      2: return swallow_flag[ch];
      default: return busy[ch];
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0: return "eq_delay_output";
      1: return "reference_output";
      2: return "swallow_flag";
      default: return "busy";
    endcase
  endfunction

  task automatic expect_at(int c, int sel, int ch, logic val);
    exp_t e;
    e.cyc = c; e.sel = sel; e.ch = ch; e.val = val;
    sbq.push_back(e);
  endtask

  // monitor: compare every expectation that falls due in this cycle
  always @(negedge clk_x10) begin
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc <= cyc) begin
        logic act;
        act = get_out(sbq[i].sel, sbq[i].ch);
        checks++;
        if (act !== sbq[i].val) begin
          errors++;
          $display("FAIL %s[%0d] cycle %0d: got %b expected %b",
                   sel_name(sbq[i].sel), sbq[i].ch, sbq[i].cyc, act, sbq[i].val);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk_x10);
    #1;
    rising_edge  = '0;
    falling_edge = '0;
    cfg_load     = 1'b0;
    swallow_clr  = 1'b0;
    g_rst        = 1'b0;
  endtask

  task automatic set_dly(int ch, int r, int f);
    rising_delay[ch*DW +: DW]  = DW'(r);
    falling_delay[ch*DW +: DW] = DW'(f);
    cfg_load = 1'b1;
    tick(); tick(); tick();
  endtask

  int t;

  initial begin
    rising_edge = '0; falling_edge = '0; rising_delay = '0; falling_delay = '0;
    cfg_load = 1'b0; bypass = '0; swallow_clr = 1'b0; g_rst = 1'b1;
    tick();
    checks++;
    if (eq_delay_output !== '0) begin
      errors++;
      $display("FAIL eq_delay_output after reset: got %b", eq_delay_output);
    end
    checks++;
    if (reference_output !== '0) begin
      errors++;
      $display("FAIL reference_output after reset: got %b", reference_output);
    end
    checks++;
    if (swallow_flag !== '0) begin
      errors++;
      $display("FAIL swallow_flag after reset: got %b", swallow_flag);
    end
    checks++;
    if (busy !== '0) begin
      errors++;
      $display("FAIL busy after reset: got %b", busy);
    end
    for (int s = 0; s < 4; s++) expect_at(cyc, s, 0, 1'b0);
    for (int s = 0; s < 4; s++) expect_at(cyc, s, 7, 1'b0);
    tick();

    // rise delay 5 on ch0
    set_dly(0, 5, 0);
    t = cyc;
    expect_at(t+1, 1, 0, 1'b1); expect_at(t+1, 3, 0, 1'b1); expect_at(t+5, 3, 0, 1'b1);
    expect_at(t+6, 3, 0, 1'b0); expect_at(t+5, 0, 0, 1'b0); expect_at(t+6, 0, 0, 1'b1);
    expect_at(t+9, 0, 0, 1'b0); expect_at(t+9, 1, 0, 1'b0); expect_at(t+9, 3, 0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) rising_edge[0] = 1'b1;
      if (i == 8) falling_edge[0] = 1'b1;
      tick();
    end

    // zero delays on ch1: output aligned with reference
    set_dly(1, 0, 0);
    t = cyc;
    expect_at(t, 0, 1, 1'b0);
    for (int j = 1; j <= 5; j++) begin
      expect_at(t+j, 0, 1, 1'b1); expect_at(t+j, 1, 1, 1'b1);
    end
    expect_at(t+6, 0, 1, 1'b0); expect_at(t+6, 1, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) rising_edge[1] = 1'b1;
      if (i == 5) falling_edge[1] = 1'b1;
      tick();
    end

    // ch2: short pulse swallowed by rise delay 9
    set_dly(2, 9, 0);
    t = cyc;
    expect_at(t+2, 0, 2, 1'b0); expect_at(t+5, 0, 2, 1'b0);
    expect_at(t+10, 0, 2, 1'b0); expect_at(t+12, 0, 2, 1'b0);
    expect_at(t+4, 3, 2, 1'b1); expect_at(t+5, 3, 2, 1'b0);
    expect_at(t+4, 2, 2, 1'b0); expect_at(t+5, 2, 2, 1'b1);
    expect_at(t+9, 2, 2, 1'b1); expect_at(t+10, 2, 2, 1'b0); expect_at(t+5, 1, 2, 1'b0);
    for (int i = 0; i < 14; i++) begin
      if (i == 0) rising_edge[2] = 1'b1;
      if (i == 4) falling_edge[2] = 1'b1;
      if (i == 9) swallow_clr = 1'b1;
      tick();
    end

    // ch3: fall cancelled by a rise, set beats a simultaneous clear
    set_dly(3, 0, 4);
    t = cyc;
    expect_at(t+1, 0, 3, 1'b1); expect_at(t+4, 0, 3, 1'b1); expect_at(t+6, 0, 3, 1'b1);
    expect_at(t+7, 0, 3, 1'b1); expect_at(t+8, 0, 3, 1'b1);
    expect_at(t+4, 3, 3, 1'b1); expect_at(t+5, 3, 3, 1'b1); expect_at(t+6, 3, 3, 1'b0);
    expect_at(t+6, 2, 3, 1'b1); expect_at(t+4, 1, 3, 1'b0); expect_at(t+6, 1, 3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) rising_edge[3] = 1'b1;
      if (i == 3) falling_edge[3] = 1'b1;
      if (i == 5) begin rising_edge[3] = 1'b1; swallow_clr = 1'b1; end
      tick();
    end

    // ch0: reload during a delay does not disturb the running delay
    set_dly(0, 7, 0);
    t = cyc;
    expect_at(t+7, 0, 0, 1'b0); expect_at(t+8, 0, 0, 1'b1);
    expect_at(t+7, 3, 0, 1'b1); expect_at(t+8, 3, 0, 1'b0);
    expect_at(t+10, 0, 0, 1'b0); expect_at(t+13, 0, 0, 1'b0);
    expect_at(t+14, 0, 0, 1'b0); expect_at(t+15, 0, 0, 1'b1);
    for (int i = 0; i < 18; i++) begin
      if (i == 0) rising_edge[0] = 1'b1;
      if (i == 2) begin rising_delay[0 +: DW] = DW'(2); cfg_load = 1'b1; end
      if (i == 9) falling_edge[0] = 1'b1;
      if (i == 12) rising_edge[0] = 1'b1;
      tick();
    end

    // ch0: simultaneous strobes in LOW act as a rise; reset mid-delay
    falling_edge[0] = 1'b1;
    tick(); tick();
    set_dly(0, 6, 0);
    t = cyc;
    expect_at(t+1, 1, 0, 1'b1); expect_at(t+1, 3, 0, 1'b1);
    expect_at(t+2, 3, 0, 1'b1); expect_at(t+2, 0, 0, 1'b0);
    for (int s = 0; s < 4; s++) expect_at(t+3, s, 0, 1'b0);
    expect_at(t+3, 0, 3, 1'b0); expect_at(t+3, 2, 3, 1'b0); expect_at(t+3, 1, 1, 1'b0);
    expect_at(t+5, 0, 0, 1'b1); expect_at(t+5, 3, 0, 1'b0); expect_at(t+5, 2, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin rising_edge[0] = 1'b1; falling_edge[0] = 1'b1; end
      if (i == 2) g_rst = 1'b1;
      if (i == 4) rising_edge[0] = 1'b1;
      tick();
    end

    // ch7: delay 31 with bypass toggled mid-delay
    set_dly(7, 31, 31);
    t = cyc;
    expect_at(t+2, 0, 7, 1'b0); expect_at(t+3, 0, 7, 1'b1); expect_at(t+9, 0, 7, 1'b1);
    expect_at(t+10, 0, 7, 1'b0); expect_at(t+20, 0, 7, 1'b0); expect_at(t+5, 1, 7, 1'b1);
    expect_at(t+31, 3, 7, 1'b1); expect_at(t+32, 3, 7, 1'b0);
    expect_at(t+31, 0, 7, 1'b0); expect_at(t+32, 0, 7, 1'b1);
    for (int i = 0; i < 36; i++) begin
      if (i == 0) rising_edge[7] = 1'b1;
      if (i == 3) bypass[7] = 1'b1;
      if (i == 10) bypass[7] = 1'b0;
      tick();
    end

    tick(); tick();
    while (sbq.size() > 0) begin
      errors++;
      $display("FAIL scoreboard leftover %s[%0d] cycle %0d", sel_name(sbq[0].sel), sbq[0].ch, sbq[0].cyc);
      void'(sbq.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
